// File: rtl/seq_pkg.sv
// Shared types and constants for the UART command sequencer.
// Segway command bytes are provided for benches that build stimulus queues.
package seq_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int GAP_W_DEF  = 24;

    localparam logic [7:0] CMD_GO   = 8'h47;
    localparam logic [7:0] CMD_STOP = 8'h53;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND      = 3'd1,
        WAIT_DONE = 3'd2,
        GAP       = 3'd3,
        FINISH    = 3'd4
    } seq_state_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] cmd;
        logic [GAP_W_DEF-1:0]  gap;
    } entry_t;

endpackage

// File: rtl/cmd_store.sv
// Entry storage for the sequencer: single write port, combinational read.
// Contents are deliberately not reset so a loaded sequence survives clr/abort semantics above it.
module cmd_store #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8,
    parameter int GAP_W  = 24,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IW-1:0]     wr_idx,
    input  logic [DATA_W-1:0] wr_cmd,
    input  logic [GAP_W-1:0]  wr_gap,
    input  logic [IW-1:0]     rd_idx,
    output logic [DATA_W-1:0] rd_cmd,
    output logic [GAP_W-1:0]  rd_gap
);

    logic [DEPTH-1:0][DATA_W-1:0] cmd_q;
    logic [DEPTH-1:0][GAP_W-1:0]  gap_q;

    always_ff @(posedge clk) begin
        if (we) begin
            cmd_q[wr_idx] <= wr_cmd;
            gap_q[wr_idx] <= wr_gap;
        end
    end

    assign rd_cmd = cmd_q[rd_idx];
    assign rd_gap = gap_q[rd_idx];

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Replays a queue of {command, gap} entries through the UART_tx trmt/tx_done handshake,
// one-shot or looping, with abort and a per-entry idle gap after each tx_done.
module uart_cmd_sequencer
    import seq_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8,
    parameter int GAP_W  = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_cmd,
    input  logic [GAP_W-1:0]         wr_gap,
    input  logic                     clr,
    input  logic                     start,
    input  logic                     loop_en,
    input  logic                     abort,
    output logic                     trmt,
    output logic [DATA_W-1:0]        tx_data,
    input  logic                     tx_done,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     busy,
    output logic                     done,
    output logic                     wr_err,
    output logic [15:0]              loop_cnt
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    seq_state_t        state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     count_q, count_d;
    logic              mode_q, mode_d;
    logic [15:0]       loop_cnt_q, loop_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              first_q, first_d;
    logic              wr_err_q, wr_err_d;
    logic              idle, wr_ok, advance;
    logic [DATA_W-1:0] rd_cmd;
    logic [GAP_W-1:0]  rd_gap;

    assign idle  = (state_q == IDLE);
    assign full  = (count_q == CW'(DEPTH));
    assign wr_ok = idle && wr_en && !clr && !full;

    cmd_store #(.DEPTH(DEPTH), .DATA_W(DATA_W), .GAP_W(GAP_W)) u_store (
        .clk    (clk),
        .we     (wr_ok),
        .wr_idx (count_q[IW-1:0]),
        .wr_cmd (wr_cmd),
        .wr_gap (wr_gap),
        .rd_idx (idx_q),
        .rd_cmd (rd_cmd),
        .rd_gap (rd_gap)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        count_d    = count_q;
        mode_d     = mode_q;
        loop_cnt_d = loop_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        tx_data_d  = tx_data_q;
        first_d    = 1'b0;
        advance    = 1'b0;
        // clr silently swallows a simultaneous write
        wr_err_d   = wr_en && !wr_ok && !(idle && clr);

        if (idle && clr)
            count_d = '0;
        else if (wr_ok)
            count_d = count_q + 1'b1;

        case (state_q)
            IDLE: begin
                // count_d already includes a same-cycle write
                if (start) begin
                    if (count_d == '0) begin
                        state_d = FINISH;
                    end else begin
                        state_d    = SEND;
                        idx_d      = '0;
                        mode_d     = loop_en;
                        loop_cnt_d = '0;
                    end
                end
            end
            SEND: begin
                tx_data_d = rd_cmd;
                first_d   = 1'b1;
                state_d   = WAIT_DONE;
            end
            WAIT_DONE: begin
                // tx_done may still be high from the previous byte in the first cycle
                if (!first_q && tx_done) begin
                    if (rd_gap == '0) begin
                        advance = 1'b1;
                    end else begin
                        gap_cnt_d = rd_gap;
                        state_d   = GAP;
                    end
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q - 1'b1;
                if (gap_cnt_q == GAP_W'(1))
                    advance = 1'b1;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (advance) begin
            if ({1'b0, idx_q} + CW'(1) < count_q) begin
                idx_d   = idx_q + 1'b1;
                state_d = SEND;
            end else if (mode_q) begin
                idx_d   = '0;
                state_d = SEND;
                if (loop_cnt_q != 16'hFFFF)
                    loop_cnt_d = loop_cnt_q + 16'd1;
            end else begin
                state_d = FINISH;
            end
        end

        if (abort && !idle)
            state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            count_q    <= '0;
            mode_q     <= 1'b0;
            loop_cnt_q <= '0;
            gap_cnt_q  <= '0;
            tx_data_q  <= '0;
            first_q    <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            mode_q     <= mode_d;
            loop_cnt_q <= loop_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            tx_data_q  <= tx_data_d;
            first_q    <= first_d;
            wr_err_q   <= wr_err_d;
        end
    end

    assign trmt     = (state_q == SEND) && !abort;
    assign tx_data  = (state_q == SEND) ? rd_cmd : tx_data_q;
    assign done     = (state_q == FINISH) && !abort;
    assign busy     = !idle;
    assign count    = count_q;
    assign wr_err   = wr_err_q;
    assign loop_cnt = loop_cnt_q;

endmodule

// File: doc/uart_cmd_sequencer.md
Name: uart_cmd_sequencer

Overview:
Programmable host-side command sequencer. It buffers up to DEPTH {command byte, gap} entries and replays them through the existing UART_tx (trmt/tx_data/tx_done handshake) to drive the Segway RX input. It supports one-shot and continuous-loop modes, abort, and a per-command inter-byte gap. It replaces hand-sequenced single-command sends with a reusable, parametrised stimulus block for system-level benches and FPGA bring-up.

Parameters:
DEPTH, 8, number of queue entries (power of 2, >=2)
DATA_W, 8, command byte width (matches UART_tx tx_data)
GAP_W, 24, width of per-entry gap count in clk cycles

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write one entry at the tail (honoured only in IDLE)
wr_cmd  in  DATA_W  command byte for the written entry
wr_gap  in  GAP_W  idle cycles inserted after this entry's tx_done
clr  in  1  empty the queue (honoured only in IDLE)
start  in  1  begin replay from entry 0
loop_en  in  1  sampled at start: 1 = continuous loop, 0 = one-shot
abort  in  1  stop replay and return to IDLE
trmt  out  1  one-cycle pulse to UART_tx
tx_data  out  DATA_W  byte presented to UART_tx, stable from trmt until tx_done
tx_done  in  1  from UART_tx, level, cleared by UART_tx on trmt
count  out  $clog2(DEPTH)+1  number of valid entries
full  out  1  count == DEPTH
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at the end of a one-shot sequence
wr_err  out  1  one-cycle pulse when wr_en is rejected (full or busy)
loop_cnt  out  16  completed loop passes, saturating at 16'hFFFF

Behaviour:
- Reset values: trmt=0, tx_data=0, count=0, busy=0, done=0, wr_err=0, loop_cnt=0, state=IDLE. Entry storage is not reset.
- Write: in IDLE with wr_en and !full, store the entry at index count and increment count. Any other wr_en pulses wr_err for 1 cycle with no state change.
- clr in IDLE sets count=0. If clr and wr_en occur together, clr wins, the write is dropped, and wr_err=0.
- FSM states: IDLE, SEND, WAIT_DONE, GAP, FINISH.
- IDLE:
  - start with count==0 -> FINISH (no trmt).
  - start otherwise -> SEND, with idx=0, latched mode=loop_en, loop_cnt=0.
  - start and wr_en in the same cycle: the write commits first, and the sequence includes the new entry.
- SEND: drive trmt=1 for exactly one cycle and tx_data=cmd[idx]. Next state is WAIT_DONE. Latency from start to trmt is 1 cycle.
- WAIT_DONE:
  - tx_done is ignored in the first cycle (guards against a stale level).
  - On tx_done=1, load gap_cnt=gap[idx]. If gap==0 the next state is the advance step directly; otherwise the next state is GAP.
- GAP: decrement gap_cnt each cycle; advance when it reaches 1 (exactly gap idle cycles).
- Advance step:
  - idx<count-1 -> idx+1, go to SEND.
  - idx==count-1 and loop mode -> idx=0, loop_cnt+1 (saturating), go to SEND.
  - idx==count-1 and one-shot -> FINISH.
- FINISH: done=1 for 1 cycle (only reached in one-shot mode), then IDLE.
- abort (any non-IDLE state, highest priority): next state is IDLE and trmt is forced to 0 that cycle. A byte already handed to UART_tx completes on the line. Queue contents and count are retained. done is not pulsed.
- tx_data holds its last value in IDLE.
- Queue contents are unchanged by replay, so the sequence can be re-started without reloading.

Decomposition:
- Shared package seq_pkg:
  - seq_state_t enum (IDLE, SEND, WAIT_DONE, GAP, FINISH)
  - entry_t struct {cmd, gap}, parametrised via localparams matching the defaults
  - Segway command constants: CMD_GO = 8'h47 ('G'), CMD_STOP = 8'h53 ('S')
- Sub-module cmd_store: DEPTH x entry_t register array with write port (index, data, we) and a combinational read at idx. The FSM, counters and handshake live in uart_cmd_sequencer.

Test Plan:
1. Load {47h, gap 0}, {53h, gap 100}; start with loop_en=0 -> trmt 1 cycle after start with tx_data=47h; second trmt 1 cycle after first tx_done; done pulse 100 gap cycles after second tx_done; exactly 2 trmt pulses in total.
2. Load 8 entries, then a 9th wr_en -> full=1, count=8, wr_err pulses, contents unchanged. clr -> count=0, full=0.
3. Loop mode with 3 entries, run 2 full passes -> loop_cnt=2, tx_data order 0,1,2,0,1,2; abort during GAP -> busy=0 next cycle, no further trmt, count still 3.
4. start with count=0 -> done 1 cycle later, trmt never asserted. wr_en while busy -> wr_err pulse, count unchanged.
5. Hold tx_done high (stale) when entering WAIT_DONE -> it is ignored for 1 cycle. With a real UART_tx into Segway RX, send 47h -> Segway powers up as with a manual send.
6. Assert rst_n low mid-WAIT_DONE -> all outputs return to reset values immediately and loop_cnt=0.
